// File: rtl/count_sched_pkg.sv
// Shared types and helpers for the counter-sharing scheduler.
package count_sched_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  // Cycles spent in RUN for a start/end window on a w-bit wrapping counter.
  function automatic int unsigned run_len(input logic [31:0] s, input logic [31:0] e,
                                          input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return int'((e - s) & mask) + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt_next,
  output logic [IW-1:0]    winner,
  output logic             any_req
);

  always_comb begin
    gnt_next = '0;
    winner   = '0;
    any_req  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any_req && req[(int'(ptr) + k) % N_REQ]) begin
        any_req = 1'b1;
        winner  = IW'((int'(ptr) + k) % N_REQ);
      end
    end
    if (any_req) gnt_next[winner] = 1'b1;
  end

endmodule

// File: rtl/count_scheduler.sv
// Round-robin owner of a shared loadable up-counter; loads the start value,
// watches the count reach the end value, then pulses done to the owner.
module count_scheduler
  import count_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] start_v,
  input  logic [N_REQ*WIDTH-1:0] end_v,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   ctr_ld,
  output logic [WIDTH-1:0]       ctr_v,
  input  logic [WIDTH-1:0]       ctr_count
);

  localparam int IW = $clog2(N_REQ);

  state_t             state_q, state_d;
  logic [IW-1:0]      owner_q, ptr_q, winner;
  logic [N_REQ-1:0]   owner_oh_q, arb_gnt;
  logic [WIDTH-1:0]   start_q, end_q;
  logic               any_req;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req      (req),
    .ptr      (ptr_q),
    .gnt_next (arb_gnt),
    .winner   (winner),
    .any_req  (any_req)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      owner_oh_q <= '0;
      ptr_q      <= '0;
      start_q    <= '0;
      end_q      <= '0;
    end else begin
      state_q <= state_d;
      // Window parameters are captured once at grant and never re-sampled.
      if (state_q == IDLE && any_req) begin
        owner_q    <= winner;
        owner_oh_q <= arb_gnt;
        start_q    <= start_v[winner*WIDTH +: WIDTH];
        end_q      <= end_v[winner*WIDTH +: WIDTH];
        ptr_q      <= (int'(winner) == N_REQ-1) ? '0 : winner + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (any_req) state_d = LOAD;
      LOAD: state_d = req[owner_q] ? RUN : IDLE;
      RUN: begin
        // Abort wins over a coincident end match.
        if (!req[owner_q])            state_d = IDLE;
        else if (ctr_count == end_q)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign ctr_ld = (state_q == LOAD);
  assign ctr_v  = start_q;
  assign grant  = busy ? owner_oh_q : '0;
  assign done   = (state_q == DONE) ? owner_oh_q : '0;

endmodule

// File: tb/tb_count_scheduler.sv
// Directed bench for count_scheduler driving a behavioural shared counter.
module tb_count_scheduler;
  import count_sched_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, grant, done;
  logic [N*W-1:0] start_v, end_v;
  logic           busy, ctr_ld, ctr_rst;
  logic [W-1:0]   ctr_v, ctr_count;
  int             total = 0;
  int             bad = 0;

  always #5 clk = ~clk;

  count_scheduler #(.WIDTH(W), .N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .start_v(start_v), .end_v(end_v),
    .grant(grant), .done(done), .busy(busy), .ctr_ld(ctr_ld), .ctr_v(ctr_v),
    .ctr_count(ctr_count)
  );

  // Shared counter with active-high reset tied to the inverted scheduler reset.
  assign ctr_rst = ~rst;
  always_ff @(posedge clk or posedge ctr_rst) begin
    if (ctr_rst)     ctr_count <= '0;
    else if (ctr_ld) ctr_count <= ctr_v;
    else             ctr_count <= ctr_count + 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_win(input int i, input logic [W-1:0] s, input logic [W-1:0] e);
    start_v[i*W +: W] = s;
    end_v[i*W +: W]   = e;
  endtask

  // Call in the first RUN cycle; returns in the DONE cycle (or after a bound).
  task automatic wait_done(input string tag, input int exp_len, input logic [N-1:0] g);
    int n;
    n = 0;
    while (done === '0 && n < 300) begin
      n++;
      tick();
    end
    chk({tag, "_runlen"}, 32'(n), 32'(exp_len));
    chk({tag, "_done"}, 32'(done), 32'(g));
    chk({tag, "_grant"}, 32'(grant), 32'(g));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; req = '0; start_v = '0; end_v = '0;
    tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ctr_ld", 32'(ctr_ld), 32'h0);
    chk("rst_ctr_v", 32'(ctr_v), 32'h0);
    rst = 1'b1;

    // Fairness: all four request zero-length windows; pointer starts at 0.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_ld", 32'(ctr_ld), 32'h1);
      chk("rr_grant", 32'(grant), 32'(1 << (i % 4)));
      tick();
      wait_done("rr", 1, 4'(1 << (i % 4)));
      tick();
      chk("rr_idle", 32'(busy), 32'h0);
    end
    req = '0;

    // Single request 0x10 -> 0x13 on requester 2.
    set_win(2, 8'h10, 8'h13);
    req = 4'b0100;
    tick();
    chk("one_ld", 32'(ctr_ld), 32'h1);
    chk("one_v", 32'(ctr_v), 32'h10);
    chk("one_grant", 32'(grant), 32'h4);
    tick();
    chk("one_ld_off", 32'(ctr_ld), 32'h0);
    chk("one_first", 32'(ctr_count), 32'h10);
    wait_done("one", 4, 4'b0100);
    req = '0;
    tick();
    chk("one_done_off", 32'(done), 32'h0);
    chk("one_grant_off", 32'(grant), 32'h0);
    chk("one_busy_off", 32'(busy), 32'h0);

    // Wrap-around window 0xFE -> 0x01 on requester 0.
    chk("fn_wrap", run_len(32'hFE, 32'h01, 8), 32'd4);
    set_win(0, 8'hFE, 8'h01);
    req = 4'b0001;
    tick();
    chk("wrap_v", 32'(ctr_v), 32'hFE);
    chk("wrap_grant", 32'(grant), 32'h1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("wrap_cnt", 32'(ctr_count), 32'(8'(8'hFE + i)));
      chk("wrap_nodone", 32'(done), 32'h0);
      tick();
    end
    chk("wrap_done", 32'(done), 32'h1);
    req = '0;
    tick();

    // Abort: requester 1 drops in RUN cycle 5 while requester 3 is pending.
    set_win(1, 8'h00, 8'h20);
    set_win(3, 8'h05, 8'h05);
    req = 4'b0010;
    tick();
    chk("ab_grant", 32'(grant), 32'h2);
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("ab_run5", 32'(ctr_count), 32'h04);
    req = 4'b1000;
    tick();
    chk("ab_grant_off", 32'(grant), 32'h0);
    chk("ab_busy_off", 32'(busy), 32'h0);
    chk("ab_nodone", 32'(done), 32'h0);
    tick();
    chk("ab_next_grant", 32'(grant), 32'h8);
    tick();
    wait_done("ab3", 1, 4'b1000);
    req = '0;
    tick();

    // Reset mid-RUN, then pointer restarts at requester 0.
    req = 4'b0100;
    tick();
    tick();
    chk("mr_inrun", 32'(busy), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("mr_grant", 32'(grant), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_ctr_ld", 32'(ctr_ld), 32'h0);
    chk("mr_done", 32'(done), 32'h0);
    tick();
    rst = 1'b1;
    req = 4'b0011;
    tick();
    chk("mr_first", 32'(grant), 32'h1);
    tick();
    wait_done("mr", 4, 4'b0001);
    req = '0;
    tick();

    // Owner's window inputs change mid-RUN; captured end value must hold.
    set_win(1, 8'h30, 8'h32);
    req = 4'b0010;
    tick();
    chk("st_grant", 32'(grant), 32'h2);
    tick();
    set_win(1, 8'h00, 8'h31);
    wait_done("st", 3, 4'b0010);
    req = '0;
    tick();
    chk("st_idle", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
